ddr3_user_arbiter: RTL and testbench
====================================

DDR3_USER_ARBITER -- requirements
Module: ddr3_user_arbiter

Interface
REQ-001 SHALL have parameters: ADDRESS_BITWIDTH, default 15, row address width; BANK_ADDRESS_BITWIDTH, default 3, bank bits; DQ_BITWIDTH, default 16, user data width; TAG_DEPTH, default 4, outstanding-read limit (power of 2).
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on posedge.
REQ-003 SHALL have ports: resetn  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports, per requester n in {0,1}: reqn_valid  in  1  request pending; reqn_write  in  1  1=write, 0=read; reqn_address  in  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  target; reqn_wdata  in  DQ_BITWIDTH  write data; reqn_ready  out  1  request taken this cycle.
REQ-005 SHALL have ports: rspn_valid  out  1  read data for requester n (n=0,1); rsp_data  out  DQ_BITWIDTH  read data, shared.
REQ-006 SHALL have controller-side ports: write_enable  out  1; read_enable  out  1; i_user_data_address  out  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH; i_user_data  out  DQ_BITWIDTH; ctrl_ready  in  1  controller accepts the driven command this cycle; o_user_data  in  DQ_BITWIDTH; o_user_data_valid  in  1  read data returned.
REQ-007 SHALL have port rsp_orphan  out  1  sticky error: read data arrived with no outstanding read.

Function
REQ-008 SHALL implement FSM states IDLE and ISSUE only.
REQ-009 In IDLE, SHALL select an eligible requester (valid=1, and if read then tag FIFO not full); both eligible -> requester != last_grant; reqn_ready pulses 1 for exactly that cycle; next state ISSUE.
REQ-010 On grant, SHALL register address, wdata, write flag and grant ID; last_grant <= granted ID.
REQ-011 In ISSUE, SHALL hold write_enable=write flag, read_enable=~write flag, address/data stable until ctrl_ready=1; then enables deassert next cycle, state -> IDLE.
REQ-012 write_enable and read_enable SHALL never be 1 simultaneously; both 0 in IDLE.
REQ-013 On read accepted (ISSUE, read, ctrl_ready=1), SHALL push grant ID into tag FIFO.
REQ-014 On o_user_data_valid=1 with FIFO non-empty, SHALL pop head ID, register rsp_data=o_user_data and assert rspn_valid for head ID one cycle later (1-cycle latency); other rsp valid 0.
REQ-015 Simultaneous push and pop SHALL both occur; occupancy unchanged; pop of empty-then-pushed same cycle is NOT allowed (empty pop = orphan).
REQ-016 o_user_data_valid with FIFO empty SHALL set rsp_orphan=1 until reset; no rsp valid asserted.
REQ-017 Read requests SHALL stall (ready=0) while FIFO holds TAG_DEPTH entries; writes from either requester still granted.
REQ-018 Minimum request-to-request throughput SHALL be one grant per 2 cycles (IDLE+ISSUE with ctrl_ready=1).
REQ-019 FIFO pointers SHALL be $clog2(TAG_DEPTH)+1 bits, wrapping modulo 2*TAG_DEPTH; full when MSBs differ and low bits equal.

Reset
REQ-020 resetn=0 SHALL immediately force: state IDLE, last_grant=1 (requester 0 wins first tie), all ready/valid/enable outputs 0, address/data/rsp_data 0, FIFO empty, rsp_orphan 0.
REQ-021 Reset mid-ISSUE SHALL abandon the command and discard all outstanding tags; no responses after reset release until new reads are issued.

Structure
REQ-022 SHALL place state encoding (IDLE/ISSUE) and default widths in shared package ddr3_pkg, reused by ddr3_memory_controller.
REQ-023 SHALL instantiate one sub-module, ddr3_tag_fifo (1-bit wide, TAG_DEPTH deep, push/pop/full/empty).

Verification
REQ-024 Both requesters valid, req0 write addr 0x00010 data 0x1234, req1 write addr 0x00020 data 0xABCD, ctrl_ready=1 -> req0 granted first, req1 next; write_enable high 2 cycles total, addresses in order.
REQ-025 req0 read addr 0x5, ctrl_ready held 0 for 5 cycles -> read_enable and address stable 5 cycles, deassert the cycle after ctrl_ready=1.
REQ-026 Interleaved reads req0, req1, req0, returns 0x1111, 0x2222, 0x3333 -> rsp0_valid/0x1111, rsp1_valid/0x2222, rsp0_valid/0x3333, each 1 cycle after o_user_data_valid.
REQ-027 Five reads with no returns (TAG_DEPTH=4) -> 5th stalled, concurrent req1 write still granted; one return releases 5th read.
REQ-028 o_user_data_valid with no outstanding read -> rsp_orphan=1, no rsp valid; resetn low mid-ISSUE -> all outputs 0 asynchronously, rsp_orphan cleared.

Source files
------------

// File: rtl/ddr3_pkg.sv
// Shared DDR3 user-side definitions: default widths and the command FSM encoding,
// common to the user arbiter and the memory controller.
package ddr3_pkg;

    localparam int DDR3_ADDRESS_BITWIDTH      = 15;
    localparam int DDR3_BANK_ADDRESS_BITWIDTH = 3;
    localparam int DDR3_DQ_BITWIDTH           = 16;
    localparam int DDR3_TAG_DEPTH             = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } ddr3_state_e;

endpackage

// File: rtl/ddr3_tag_fifo.sv
// In-order FIFO of 1-bit requester IDs for reads accepted by the controller.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ddr3_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head_id,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign head_id = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_id;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/ddr3_user_arbiter.sv
// Two-requester round-robin front end for the DDR3 controller user port.
// Read return data is routed back to its requester via an in-order tag FIFO.
module ddr3_user_arbiter
    import ddr3_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH      = DDR3_ADDRESS_BITWIDTH,
    parameter int BANK_ADDRESS_BITWIDTH = DDR3_BANK_ADDRESS_BITWIDTH,
    parameter int DQ_BITWIDTH           = DDR3_DQ_BITWIDTH,
    parameter int TAG_DEPTH             = DDR3_TAG_DEPTH
) (
    input  logic                                            clk,
    input  logic                                            resetn,
    input  logic                                            req0_valid,
    input  logic                                            req0_write,
    input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] req0_address,
    input  logic [DQ_BITWIDTH-1:0]                          req0_wdata,
    output logic                                            req0_ready,
    input  logic                                            req1_valid,
    input  logic                                            req1_write,
    input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] req1_address,
    input  logic [DQ_BITWIDTH-1:0]                          req1_wdata,
    output logic                                            req1_ready,
    output logic                                            rsp0_valid,
    output logic                                            rsp1_valid,
    output logic [DQ_BITWIDTH-1:0]                          rsp_data,
    output logic                                            write_enable,
    output logic                                            read_enable,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]                          i_user_data,
    input  logic                                            ctrl_ready,
    input  logic [DQ_BITWIDTH-1:0]                          o_user_data,
    input  logic                                            o_user_data_valid,
    output logic                                            rsp_orphan
);

    localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;

    ddr3_state_e          state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 gnt_id_q, gnt_id_d;
    logic                 wr_q, wr_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DQ_BITWIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]           rsp_valid_q, rsp_valid_d;
    logic [DQ_BITWIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                 orphan_q, orphan_d;

    logic elig0, elig1, gnt0, gnt1;
    logic tag_push, tag_pop, tag_head, tag_full, tag_empty;

    // Reads are only eligible while a tag slot is free; writes never need one.
    always_comb begin
        elig0 = req0_valid && (req0_write || !tag_full);
        elig1 = req1_valid && (req1_write || !tag_full);
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        if (state_q == IDLE) begin
            if (elig0 && elig1) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d      = ISSUE;
                    gnt_id_d     = gnt1;
                    last_grant_d = gnt1;
                    wr_d         = gnt1 ? req1_write   : req0_write;
                    addr_d       = gnt1 ? req1_address : req0_address;
                    wdata_d      = gnt1 ? req1_wdata   : req0_wdata;
                end
            end
            ISSUE: begin
                if (ctrl_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tag_push = (state_q == ISSUE) && !wr_q && ctrl_ready;
    assign tag_pop  = o_user_data_valid && !tag_empty;

    // Return data with no outstanding tag is flagged, never routed.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        orphan_d    = orphan_q || (o_user_data_valid && tag_empty);
        if (tag_pop) begin
            rsp_valid_d[tag_head] = 1'b1;
            rsp_data_d            = o_user_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_id_q     <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            orphan_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            orphan_q     <= orphan_d;
        end
    end

    ddr3_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (tag_push),
        .push_id (gnt_id_q),
        .pop     (tag_pop),
        .head_id (tag_head),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    // Ready is combinational off the inputs, so it is also gated by reset directly.
    assign req0_ready          = gnt0 && resetn;
    assign req1_ready          = gnt1 && resetn;
    assign write_enable        = (state_q == ISSUE) && wr_q;
    assign read_enable         = (state_q == ISSUE) && !wr_q;
    assign i_user_data_address = addr_q;
    assign i_user_data         = wdata_q;
    assign rsp0_valid          = rsp_valid_q[0];
    assign rsp1_valid          = rsp_valid_q[1];
    assign rsp_data            = rsp_data_q;
    assign rsp_orphan          = orphan_q;

endmodule

// File: tb/tb_ddr3_user_arbiter.sv
// Scoreboard bench for ddr3_user_arbiter: expected commands and responses are queued
// as stimulus is driven and checked by a negedge monitor.
module tb_ddr3_user_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          req0_valid, req0_write, req0_ready;
    logic [AW-1:0] req0_address;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_write, req1_ready;
    logic [AW-1:0] req1_address;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_data;
    logic          write_enable, read_enable;
    logic [AW-1:0] i_user_data_address;
    logic [DW-1:0] i_user_data;
    logic          ctrl_ready;
    logic [DW-1:0] o_user_data;
    logic          o_user_data_valid;
    logic          rsp_orphan;

    int n_chk  = 0;
    int n_fail = 0;
    int we_cnt = 0;

    logic [AW+DW:0] cmd_q[$];   // {write, address, write ? data : 0}
    logic [DW+1:0]  rsp_q[$];   // {rsp1_valid, rsp0_valid, data}

    always #5 clk = ~clk;

    ddr3_user_arbiter dut (
        .clk                 (clk),
        .resetn              (resetn),
        .req0_valid          (req0_valid),
        .req0_write          (req0_write),
        .req0_address        (req0_address),
        .req0_wdata          (req0_wdata),
        .req0_ready          (req0_ready),
        .req1_valid          (req1_valid),
        .req1_write          (req1_write),
        .req1_address        (req1_address),
        .req1_wdata          (req1_wdata),
        .req1_ready          (req1_ready),
        .rsp0_valid          (rsp0_valid),
        .rsp1_valid          (rsp1_valid),
        .rsp_data            (rsp_data),
        .write_enable        (write_enable),
        .read_enable         (read_enable),
        .i_user_data_address (i_user_data_address),
        .i_user_data         (i_user_data),
        .ctrl_ready          (ctrl_ready),
        .o_user_data         (o_user_data),
        .o_user_data_valid   (o_user_data_valid),
        .rsp_orphan          (rsp_orphan)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        logic [AW+DW:0] ce;
        logic [DW+1:0]  re;
        if (resetn) begin
            if (write_enable) we_cnt++;
            if (write_enable || read_enable) chk("en_excl", write_enable & read_enable, 0);
            if ((write_enable || read_enable) && ctrl_ready) begin
                if (cmd_q.size() == 0) chk("cmd_unexp", 1, 0);
                else begin
                    ce = cmd_q.pop_front();
                    chk("cmd", {write_enable, i_user_data_address, write_enable ? i_user_data : '0}, ce);
                end
            end
            if (rsp0_valid || rsp1_valid) begin
                if (rsp_q.size() == 0) chk("rsp_unexp", {rsp1_valid, rsp0_valid}, 0);
                else begin
                    re = rsp_q.pop_front();
                    chk("rsp", {rsp1_valid, rsp0_valid, rsp_data}, re);
                end
            end
        end
    end

    task automatic do_req(input int n, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 1'b0;
        cmd_q.push_back({wr, a, wr ? d : '0});
        if (n == 0) begin
            req0_valid = 1'b1; req0_write = wr; req0_address = a; req0_wdata = d;
        end else begin
            req1_valid = 1'b1; req1_write = wr; req1_address = a; req1_wdata = d;
        end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (n == 0) ? req0_ready : req1_ready;
        end
        chk("req_grant", ok, 1);
        @(posedge clk); #1;
        if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic ret(input logic [DW-1:0] d, input int id);
        @(posedge clk); #1;
        rsp_q.push_back({id == 1, id == 0, d});
        o_user_data       = d;
        o_user_data_valid = 1'b1;
        @(posedge clk); #1;
        o_user_data_valid = 1'b0;
        @(negedge clk);
        chk("rsp_lat", {rsp1_valid, rsp0_valid}, (id == 1) ? 2'b10 : 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        resetn = 1'b0;
        req0_valid = 1'b1; req0_write = 1'b0; req0_address = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_address = '0; req1_wdata = '0;
        ctrl_ready = 1'b0; o_user_data = '0; o_user_data_valid = 1'b0;

        // reset state, with a request already pending
        #12;
        chk("rst_ready",  {req1_ready, req0_ready}, 0);
        chk("rst_en",     {write_enable, read_enable}, 0);
        chk("rst_addr",   i_user_data_address, 0);
        chk("rst_data",   i_user_data, 0);
        chk("rst_rsp",    {rsp1_valid, rsp0_valid, rsp_data}, 0);
        chk("rst_orphan", rsp_orphan, 0);
        req0_valid = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;

        // simultaneous writes: req0 wins the first tie, then req1
        @(posedge clk); #1;
        ctrl_ready = 1'b1;
        cmd_q.push_back({1'b1, 18'h00010, 16'h1234});
        cmd_q.push_back({1'b1, 18'h00020, 16'hABCD});
        req0_valid = 1'b1; req0_write = 1'b1; req0_address = 18'h00010; req0_wdata = 16'h1234;
        req1_valid = 1'b1; req1_write = 1'b1; req1_address = 18'h00020; req1_wdata = 16'hABCD;
        we_cnt = 0;
        @(negedge clk); chk("t1_first", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk); chk("t1_issue0", {req1_ready, write_enable}, 2'b01);
        @(posedge clk); #1;
        @(negedge clk); chk("t1_second", {req1_ready, write_enable}, 2'b10);
        @(posedge clk); #1 req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_we_cycles", we_cnt, 2);

        // read held by ctrl_ready=0 for 5 cycles
        @(posedge clk); #1 ctrl_ready = 1'b0;
        do_req(0, 1'b0, 18'h00005, 16'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold", {read_enable, write_enable, i_user_data_address}, {2'b10, 18'h00005});
            @(posedge clk); #1;
        end
        ctrl_ready = 1'b1;
        @(negedge clk); chk("t2_accept", read_enable, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("t2_release", read_enable, 0);
        ret(16'h5555, 0);

        // interleaved reads routed back in order
        @(posedge clk); #1;
        do_req(0, 1'b0, 18'h00100, 16'h0);
        do_req(1, 1'b0, 18'h00200, 16'h0);
        do_req(0, 1'b0, 18'h00300, 16'h0);
        ret(16'h1111, 0);
        ret(16'h2222, 1);
        ret(16'h3333, 0);

        // tag FIFO full: fifth read stalls, write still goes through
        @(posedge clk); #1;
        do_req(0, 1'b0, 18'h00400, 16'h0);
        do_req(1, 1'b0, 18'h00401, 16'h0);
        do_req(0, 1'b0, 18'h00402, 16'h0);
        do_req(1, 1'b0, 18'h00403, 16'h0);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_address = 18'h00404;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("t4_stall", req0_ready, 0);
        end
        @(posedge clk); #1;
        do_req(1, 1'b1, 18'h00405, 16'hBEEF);
        @(posedge clk); #1;
        @(negedge clk); chk("t4_stall_after_w", req0_ready, 0);
        cmd_q.push_back({1'b0, 18'h00404, 16'h0});
        ret(16'hA000, 0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req0_ready) ok = 1'b1;
            else @(negedge clk);
        end
        chk("t4_release", ok, 1);
        @(posedge clk); #1 req0_valid = 1'b0;
        ret(16'hA001, 1);
        ret(16'hA002, 0);
        ret(16'hA003, 1);
        ret(16'hA004, 0);

        // orphan return data
        @(posedge clk); #1;
        o_user_data = 16'hDEAD; o_user_data_valid = 1'b1;
        @(posedge clk); #1 o_user_data_valid = 1'b0;
        @(negedge clk);
        chk("t5_orphan", rsp_orphan, 1);
        chk("t5_no_rsp", {rsp1_valid, rsp0_valid}, 0);
        repeat (3) @(negedge clk);
        chk("t5_sticky", rsp_orphan, 1);

        // reset in the middle of an ISSUE with a tag outstanding
        @(posedge clk); #1;
        do_req(1, 1'b0, 18'h00500, 16'h0);
        @(posedge clk); #1 ctrl_ready = 1'b0;
        do_req(0, 1'b0, 18'h00501, 16'h0);
        @(negedge clk); chk("t6_pre", read_enable, 1);
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_en",     {write_enable, read_enable, req1_ready, req0_ready}, 0);
        chk("t6_rst_addr",   i_user_data_address, 0);
        chk("t6_rst_rsp",    {rsp1_valid, rsp0_valid, rsp_data}, 0);
        chk("t6_rst_orphan", rsp_orphan, 0);
        cmd_q.delete();
        @(posedge clk); #1 resetn = 1'b1; ctrl_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle", {write_enable, read_enable, rsp_orphan}, 0);
        @(posedge clk); #1;
        o_user_data = 16'hBEAD; o_user_data_valid = 1'b1;
        @(posedge clk); #1 o_user_data_valid = 1'b0;
        @(negedge clk);
        chk("t6_tags_gone", rsp_orphan, 1);
        chk("t6_no_rsp", {rsp1_valid, rsp0_valid}, 0);

        repeat (2) @(negedge clk);
        chk("cmd_q_empty", cmd_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
